image_dump_controller: RTL
==========================

Name: image_dump_controller

Overview:
Reverse path of the UART image streaming path. On a host command received over UART, reads the whole image buffer sequentially through the single_port_ram request/ready handshake and sends it back over the UART transmitter, framed by a 2-byte header and a 1-byte XOR checksum. It sits beside the streaming controller, on the buffer port the top-level mux selects, and drives the UART transmitter inputs (send strobe, data).

Parameters:
IMAGE_BUF_X, 40, image buffer width in pixels
IMAGE_BUF_Y, 30, image buffer height in pixels
CMD_DUMP, 8'h44, command byte that starts a dump ('D')
CMD_ABORT, 8'h58, command byte that aborts a dump ('X')
(derived, not overridable) BUF_BYTES = IMAGE_BUF_X*IMAGE_BUF_Y*2

Ports:
clk  in  1  system clock; sole clock domain
reset  in  1  synchronous, active-high reset
rx_data  in  8  received UART byte, valid when rx_ready=1
rx_ready  in  1  one-cycle strobe: rx_data valid
tx_busy  in  1  UART transmitter busy
mem_out  in  8  buffer read data, valid in the cycle mem_ready=1
mem_ready  in  1  buffer access-complete strobe
tx_data  out  8  byte to transmit
tx_ready  out  1  one-cycle send strobe to UART transmitter
mem_req  out  1  buffer read request
mem_addr  out  32  buffer byte address
dump_active  out  1  high from command accept until the dump ends or aborts
dump_ended  out  1  one-cycle pulse after the checksum byte finishes sending

Behaviour:
- Single clock, clk. reset is synchronous and active-high. In any cycle with reset=1, all state goes to IDLE and every output goes to 0: tx_data=0, tx_ready=0, mem_req=0, mem_addr=0, dump_active=0, dump_ended=0. The XOR accumulator and byte counter also clear.
- Reset mid-dump: the dump ends immediately. No further tx_ready pulses. The next dump starts again from the header.
- IDLE: on rx_ready=1 with rx_data==CMD_DUMP, go to HDR0 and set dump_active=1 in the next cycle. All other bytes are ignored.
- Send rules (every byte):
  - SEND: pulse tx_ready for exactly 1 cycle, only when tx_busy=0; tx_data is stable from that cycle until tx_busy falls.
  - ARM: wait 1 cycle after the strobe, so the transmitter has time to assert busy.
  - WAIT: wait until tx_busy=0.
  - At most one tx_ready pulse per byte.
- HDR0: send 8'hA5. HDR1: send 8'h5A.
- MEM_REQ: assert mem_req=1 with mem_addr = the byte counter (0 to BUF_BYTES-1).
  - mem_req and mem_addr stay constant until mem_ready=1. Latency is unbounded.
  - In the mem_ready cycle, capture mem_out into tx_data and XOR it into the checksum.
  - mem_req drops to 0 in the next cycle, then the byte is sent.
- After each data byte's WAIT completes:
  - if counter == BUF_BYTES-1, go to CHECKSUM;
  - otherwise increment counter and mem_addr by 1 and return to MEM_REQ.
- Address/counter width is 32 bits, zero-extended. No wrap: the counter never exceeds BUF_BYTES-1.
- CHECKSUM: send the XOR of all BUF_BYTES data bytes. Header bytes are excluded.
- DONE: pulse dump_ended=1 for 1 cycle; in the same cycle clear dump_active, mem_addr and the counter. Return to IDLE.
- Commands while dump_active=1:
  - CMD_DUMP is ignored.
  - CMD_ABORT takes effect in the next cycle.
    - If a byte is mid-send, finish its WAIT first.
    - If in MEM_REQ, wait for mem_ready and discard the data.
    - Then go to IDLE with dump_active=0. No checksum byte and no dump_ended pulse.
  - The abort is latched; it is never lost even if it arrives during a wait.
- Simultaneous rx_ready and mem_ready/tx_busy events: both are handled in the same cycle; neither is dropped.
- mem_ready while mem_req=0 is ignored.
- Latency: CMD_DUMP strobe to the first tx_ready pulse = 2 cycles when tx_busy=0.

Test Plan:
- Full dump: IMAGE_BUF_X=4, IMAGE_BUF_Y=2 (16 bytes); memory returns addr+1 with 3-cycle latency; UART model with busy 10 cycles; send 8'h44 -> tx sequence A5,5A,01..10,10 (checksum 0x10), then dump_ended is a single pulse and dump_active falls.
- Ignored input: send 8'h41, 8'h58, 8'h00 while IDLE -> no tx_ready, no mem_req, dump_active stays 0.
- Abort: start a dump, send 8'h58 while byte 5 is in flight -> byte 5 completes, no further tx_ready, no checksum, no dump_ended, dump_active=0; a new 8'h44 restarts at A5 with mem_addr=0.
- Re-command: 8'h44 sent mid-dump -> ignored; exactly 19 bytes are sent in total.
- Reset mid-dump: assert reset during MEM_REQ with mem_ready withheld -> next cycle all outputs are 0; after release there is no activity until a new command.
- Handshake stress: random mem_ready latency 0-20 cycles plus an mem_ready pulse arriving while mem_req=0 -> mem_addr is stable while mem_req=1, bytes are correct, and the stray mem_ready is ignored.

Source files
------------

// File: rtl/image_dump_controller_if.sv
// Signal bundle between the image dump controller and its UART receiver,
// UART transmitter and image buffer port.
interface image_dump_controller_if;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_busy;
   logic [7:0]  mem_out;
   logic        mem_ready;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        dump_active;
   logic        dump_ended;

   modport master (
      input  rx_data, rx_ready, tx_busy, mem_out, mem_ready,
      output tx_data, tx_ready, mem_req, mem_addr, dump_active, dump_ended
   );

   modport slave (
      output rx_data, rx_ready, tx_busy, mem_out, mem_ready,
      input  tx_data, tx_ready, mem_req, mem_addr, dump_active, dump_ended
   );
endinterface

// File: rtl/image_dump_controller.sv
// Dumps the image buffer over UART on a host command: A5 5A header, every
// buffer byte in address order, then the XOR of the data bytes.
module image_dump_controller #(
   parameter int         IMAGE_BUF_X = 40,
   parameter int         IMAGE_BUF_Y = 30,
   parameter logic [7:0] CMD_DUMP    = 8'h44,
   parameter logic [7:0] CMD_ABORT   = 8'h58
) (
   input logic                     clk,
   input logic                     reset,
   image_dump_controller_if.master bus
);
   localparam int          BUF_BYTES = IMAGE_BUF_X * IMAGE_BUF_Y * 2;
   localparam logic [31:0] LAST_IDX  = 32'(BUF_BYTES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR0, S_HDR1, S_MEM_REQ, S_DATA, S_CSUM, S_ARM, S_WAIT, S_DONE
   } state_t;

   typedef enum logic [1:0] {B_HDR0, B_HDR1, B_DATA, B_CSUM} kind_t;

   state_t      state_q, state_d;
   kind_t       kind_q, kind_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_ready_q, tx_ready_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] cnt_q, cnt_d;
   logic        dump_active_q, dump_active_d;
   logic        dump_ended_q, dump_ended_d;
   logic [7:0]  csum_q, csum_d;
   logic        abort_q, abort_d;
   logic        abort_exit;
   logic        cmd_dump, cmd_abort;

   assign cmd_dump  = bus.rx_ready && (bus.rx_data == CMD_DUMP);
   assign cmd_abort = bus.rx_ready && (bus.rx_data == CMD_ABORT);

   always_comb begin
      state_d       = state_q;
      kind_d        = kind_q;
      tx_data_d     = tx_data_q;
      tx_ready_d    = 1'b0;
      mem_req_d     = mem_req_q;
      cnt_d         = cnt_q;
      dump_active_d = dump_active_q;
      dump_ended_d  = 1'b0;
      csum_d        = csum_q;
      abort_d       = abort_q | (dump_active_q & cmd_abort);
      abort_exit    = 1'b0;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (cmd_dump) begin
               state_d       = S_HDR0;
               dump_active_d = 1'b1;
               cnt_d         = '0;
               csum_d        = '0;
               abort_d       = 1'b0;
            end
         end
         S_HDR0, S_HDR1, S_DATA, S_CSUM: begin
            if (abort_q) begin
               abort_exit = 1'b1;
            end else if (!bus.tx_busy) begin
               tx_ready_d = 1'b1;
               state_d    = S_ARM;
               unique case (state_q)
                  S_HDR0: begin tx_data_d = 8'hA5;  kind_d = B_HDR0; end
                  S_HDR1: begin tx_data_d = 8'h5A;  kind_d = B_HDR1; end
                  S_CSUM: begin tx_data_d = csum_q; kind_d = B_CSUM; end
                  // data byte already sits in tx_data since the mem_ready cycle
                  default: kind_d = B_DATA;
               endcase
            end
         end
         S_ARM: state_d = S_WAIT;
         S_WAIT: begin
            if (!bus.tx_busy) begin
               if (abort_q) begin
                  abort_exit = 1'b1;
               end else begin
                  unique case (kind_q)
                     B_HDR0: state_d = S_HDR1;
                     B_HDR1: begin
                        state_d   = S_MEM_REQ;
                        mem_req_d = 1'b1;
                     end
                     B_DATA: begin
                        if (cnt_q == LAST_IDX) begin
                           state_d = S_CSUM;
                        end else begin
                           cnt_d     = cnt_q + 32'd1;
                           state_d   = S_MEM_REQ;
                           mem_req_d = 1'b1;
                        end
                     end
                     default: begin
                        state_d       = S_DONE;
                        dump_ended_d  = 1'b1;
                        dump_active_d = 1'b0;
                        cnt_d         = '0;
                        abort_d       = 1'b0;
                     end
                  endcase
               end
            end
         end
         S_MEM_REQ: begin
            if (bus.mem_ready) begin
               mem_req_d = 1'b0;
               if (abort_q) begin
                  abort_exit = 1'b1;
               end else begin
                  tx_data_d = bus.mem_out;
                  csum_d    = csum_q ^ bus.mem_out;
                  state_d   = S_DATA;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Aborted dumps end silently: no checksum, no dump_ended pulse.
      if (abort_exit) begin
         state_d       = S_IDLE;
         dump_active_d = 1'b0;
         mem_req_d     = 1'b0;
         cnt_d         = '0;
         abort_d       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         kind_q        <= B_HDR0;
         tx_data_q     <= '0;
         tx_ready_q    <= 1'b0;
         mem_req_q     <= 1'b0;
         cnt_q         <= '0;
         dump_active_q <= 1'b0;
         dump_ended_q  <= 1'b0;
         csum_q        <= '0;
         abort_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         kind_q        <= kind_d;
         tx_data_q     <= tx_data_d;
         tx_ready_q    <= tx_ready_d;
         mem_req_q     <= mem_req_d;
         cnt_q         <= cnt_d;
         dump_active_q <= dump_active_d;
         dump_ended_q  <= dump_ended_d;
         csum_q        <= csum_d;
         abort_q       <= abort_d;
      end
   end

   assign bus.tx_data     = tx_data_q;
   assign bus.tx_ready    = tx_ready_q;
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_addr    = cnt_q;
   assign bus.dump_active = dump_active_q;
   assign bus.dump_ended  = dump_ended_q;
endmodule
